// File: rtl/bmain_arbiter.sv
// ----------------------------------------------------------------------------
// bmain_arbiter
//
// Purpose:
//   Two-requester bus arbiter. It connects the fe1 fetch port (read-only) and
//   the mem1 load/store port to a single downstream bus. One transaction is in
//   flight at a time. Each transaction goes IDLE -> CMD -> XFER -> IDLE.
//   The owner, command and address are captured when arbitration is won. They
//   hold until the FSM returns to IDLE, so a pending request never
//   re-arbitrates mid-transaction.
//
// Configuration:
//   BMAIN_ARB_RR_EN  defined   : round-robin; when both request, the one that
//                                is not last_owner wins.
//                    undefined : fixed priority, mem1 over fe1 (default).
//
// Ports:
//   clk_core, reset_n       core clock; synchronous active-low reset
//   fe1_*                   fe1 command/read/error-ack inputs (always read)
//   mem1_*                  mem1 command/write/read/error-ack inputs
//   bmain_*_fe1/_mem1       per-requester ready/valid/error outputs
//   bmain_rdata/rlast       read data broadcast straight from the bus
//   bus_*                   downstream bus command/write/read/error channels
// ----------------------------------------------------------------------------
module bmain_arbiter (
    input  logic        clk_core,
    input  logic        reset_n,

    input  logic        fe1_cvalid,
    input  logic [26:0] fe1_addr,
    input  logic        fe1_rready,
    input  logic        fe1_eack,
    output logic        bmain_cready_fe1,
    output logic        bmain_rvalid_fe1,
    output logic        bmain_error_fe1,

    input  logic        mem1_cvalid,
    input  logic        mem1_cmd,
    input  logic [26:0] mem1_addr,
    input  logic        mem1_wvalid,
    input  logic        mem1_wlast,
    input  logic [31:0] mem1_wdata,
    input  logic [3:0]  mem1_wmask,
    input  logic        mem1_rready,
    input  logic        mem1_eack,
    output logic        bmain_cready_mem1,
    output logic        bmain_wready_mem1,
    output logic        bmain_rvalid_mem1,
    output logic        bmain_error_mem1,

    output logic [31:0] bmain_rdata,
    output logic        bmain_rlast,

    output logic        bus_cvalid,
    input  logic        bus_cready,
    output logic        bus_cmd,
    output logic [26:0] bus_addr,
    output logic        bus_wvalid,
    input  logic        bus_wready,
    output logic        bus_wlast,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_rvalid,
    output logic        bus_rready,
    input  logic        bus_rlast,
    input  logic [31:0] bus_rdata,
    input  logic        bus_error,
    output logic        bus_eack
);

    // One-hot FSM encoding
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_CMD  = 3'b010;
    localparam logic [2:0] ST_XFER = 3'b100;

    localparam logic OWN_MEM1 = 1'b0;
    localparam logic OWN_FE1  = 1'b1;

    logic [2:0]  r_state;
    logic        r_owner;
    logic        r_last_owner;
    logic        r_cmd;          // 1 = read, 0 = write
    logic [26:0] r_addr;

    logic w_any_req;
    logic w_win;
    logic w_in_idle;
    logic w_in_cmd;
    logic w_in_xfer;
    logic w_busy;
    logic w_own_fe1;
    logic w_rd_xfer;
    logic w_wr_xfer;
    logic w_err_done;
    logic w_rd_done;
    logic w_wr_done;

    // ------------------------------------------------------------------------
    // Arbitration: evaluated only in IDLE
    // ------------------------------------------------------------------------
    assign w_any_req = fe1_cvalid | mem1_cvalid;

`ifdef BMAIN_ARB_RR_EN
    // On a tie, the requester that did not own the last granted command wins.
    assign w_win = (fe1_cvalid & mem1_cvalid)
                 ? ((r_last_owner == OWN_FE1) ? OWN_MEM1 : OWN_FE1)
                 : (fe1_cvalid ? OWN_FE1 : OWN_MEM1);
`else
    assign w_win = mem1_cvalid ? OWN_MEM1 : OWN_FE1;
`endif

    // ------------------------------------------------------------------------
    // State decode
    // ------------------------------------------------------------------------
    assign w_in_idle = (r_state == ST_IDLE);
    assign w_in_cmd  = (r_state == ST_CMD);
    assign w_in_xfer = (r_state == ST_XFER);
    assign w_busy    = w_in_cmd | w_in_xfer;
    assign w_own_fe1 = (r_owner == OWN_FE1);
    assign w_rd_xfer = w_in_xfer & r_cmd;
    // fe1 is always captured with r_cmd=1, so a write transfer always belongs to mem1.
    assign w_wr_xfer = w_in_xfer & ~r_cmd & ~w_own_fe1;

    // ------------------------------------------------------------------------
    // Bus-side outputs: all zero in IDLE except the error drain on bus_eack
    // ------------------------------------------------------------------------
    assign bus_cvalid = w_in_cmd;
    assign bus_cmd    = w_busy & r_cmd;
    assign bus_addr   = w_busy ? r_addr : 27'd0;

    assign bus_wvalid = w_wr_xfer & mem1_wvalid;
    assign bus_wlast  = w_wr_xfer & mem1_wlast;
    assign bus_wdata  = w_wr_xfer ? mem1_wdata : 32'd0;
    assign bus_wmask  = w_wr_xfer ? mem1_wmask : 4'd0;

    assign bus_rready = w_rd_xfer & (w_own_fe1 ? fe1_rready : mem1_rready);

    // In IDLE, a stray bus error is acknowledged immediately so it cannot
    // stall the bus waiting for an owner that does not exist.
    assign bus_eack = w_busy ? (w_own_fe1 ? fe1_eack : mem1_eack)
                             : (w_in_idle & bus_error);

    // ------------------------------------------------------------------------
    // Requester-side outputs: the non-owner always sees zeros
    // ------------------------------------------------------------------------
    assign bmain_cready_fe1  = w_in_cmd  &  w_own_fe1 & bus_cready;
    assign bmain_cready_mem1 = w_in_cmd  & ~w_own_fe1 & bus_cready;
    assign bmain_wready_mem1 = w_wr_xfer & bus_wready;
    assign bmain_rvalid_fe1  = w_rd_xfer &  w_own_fe1 & bus_rvalid;
    assign bmain_rvalid_mem1 = w_rd_xfer & ~w_own_fe1 & bus_rvalid;
    assign bmain_error_fe1   = w_busy    &  w_own_fe1 & bus_error;
    assign bmain_error_mem1  = w_busy    & ~w_own_fe1 & bus_error;

    assign bmain_rdata = bus_rdata;
    assign bmain_rlast = bus_rlast;

    // ------------------------------------------------------------------------
    // Transaction termination
    // ------------------------------------------------------------------------
    assign w_err_done = w_busy & bus_error & bus_eack;
    assign w_rd_done  = w_rd_xfer & bus_rvalid & bus_rready & bus_rlast;
    assign w_wr_done  = w_wr_xfer & bus_wvalid & bus_wready & bus_wlast;

    // ------------------------------------------------------------------------
    // FSM and transaction registers
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values of the others.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_MEM1;
            r_last_owner <= OWN_FE1;
            r_cmd        <= 1'b0;
            r_addr       <= 27'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        // Capture command and address here so the bus sees
                        // stable values even if the requester changes them later.
                        r_owner <= w_win;
                        r_cmd   <= (w_win == OWN_FE1) ? 1'b1 : mem1_cmd;
                        r_addr  <= (w_win == OWN_FE1) ? fe1_addr : mem1_addr;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // An acknowledged error aborts the transaction even if
                    // bus_cready arrives in the same cycle.
                    if (w_err_done) begin
                        r_state <= ST_IDLE;
                    end else if (bus_cready) begin
                        r_last_owner <= r_owner;
                        r_state      <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_err_done || w_rd_done || w_wr_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmain_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bmain_arbiter
//
// Bench for bmain_arbiter. Expected grants {owner, cmd, addr} and write beats
// are queued when the requester stimulus is driven. They are popped and
// compared when the bus shows the command handshake or the write beat.
// Inputs change 1 time unit after posedge. Outputs are sampled on negedge.
// ----------------------------------------------------------------------------
module tb_bmain_arbiter;

    localparam logic O_MEM1 = 1'b0;
    localparam logic O_FE1  = 1'b1;

    typedef struct packed {
        logic        owner;
        logic        cmd;
        logic [26:0] addr;
    } cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        last;
    } beat_t;

    logic        clk_core = 1'b0;
    logic        reset_n;
    logic        fe1_cvalid, fe1_rready, fe1_eack;
    logic [26:0] fe1_addr;
    logic        bmain_cready_fe1, bmain_rvalid_fe1, bmain_error_fe1;
    logic        mem1_cvalid, mem1_cmd, mem1_wvalid, mem1_wlast, mem1_rready, mem1_eack;
    logic [26:0] mem1_addr;
    logic [31:0] mem1_wdata;
    logic [3:0]  mem1_wmask;
    logic        bmain_cready_mem1, bmain_wready_mem1, bmain_rvalid_mem1, bmain_error_mem1;
    logic [31:0] bmain_rdata;
    logic        bmain_rlast;
    logic        bus_cvalid, bus_cready, bus_cmd;
    logic [26:0] bus_addr;
    logic        bus_wvalid, bus_wready, bus_wlast;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_rvalid, bus_rready, bus_rlast;
    logic [31:0] bus_rdata;
    logic        bus_error, bus_eack;

    cmd_t  cmd_q[$];
    beat_t beat_q[$];
    int    n_err = 0;
    int    n_chk = 0;

    always #5 clk_core = ~clk_core;

    bmain_arbiter dut (
        .clk_core          (clk_core),
        .reset_n           (reset_n),
        .fe1_cvalid        (fe1_cvalid),
        .fe1_addr          (fe1_addr),
        .fe1_rready        (fe1_rready),
        .fe1_eack          (fe1_eack),
        .bmain_cready_fe1  (bmain_cready_fe1),
        .bmain_rvalid_fe1  (bmain_rvalid_fe1),
        .bmain_error_fe1   (bmain_error_fe1),
        .mem1_cvalid       (mem1_cvalid),
        .mem1_cmd          (mem1_cmd),
        .mem1_addr         (mem1_addr),
        .mem1_wvalid       (mem1_wvalid),
        .mem1_wlast        (mem1_wlast),
        .mem1_wdata        (mem1_wdata),
        .mem1_wmask        (mem1_wmask),
        .mem1_rready       (mem1_rready),
        .mem1_eack         (mem1_eack),
        .bmain_cready_mem1 (bmain_cready_mem1),
        .bmain_wready_mem1 (bmain_wready_mem1),
        .bmain_rvalid_mem1 (bmain_rvalid_mem1),
        .bmain_error_mem1  (bmain_error_mem1),
        .bmain_rdata       (bmain_rdata),
        .bmain_rlast       (bmain_rlast),
        .bus_cvalid        (bus_cvalid),
        .bus_cready        (bus_cready),
        .bus_cmd           (bus_cmd),
        .bus_addr          (bus_addr),
        .bus_wvalid        (bus_wvalid),
        .bus_wready        (bus_wready),
        .bus_wlast         (bus_wlast),
        .bus_wdata         (bus_wdata),
        .bus_wmask         (bus_wmask),
        .bus_rvalid        (bus_rvalid),
        .bus_rready        (bus_rready),
        .bus_rlast         (bus_rlast),
        .bus_rdata         (bus_rdata),
        .bus_error         (bus_error),
        .bus_eack          (bus_eack)
    );

    // ---------------------------------------------------------------- helpers
    task automatic next_cycle();
        @(posedge clk_core);
        #1;
    endtask

    task automatic idle_inputs();
        fe1_cvalid = 0; fe1_addr = '0; fe1_rready = 0; fe1_eack = 0;
        mem1_cvalid = 0; mem1_cmd = 0; mem1_addr = '0; mem1_wvalid = 0;
        mem1_wlast = 0; mem1_wdata = '0; mem1_wmask = '0; mem1_rready = 0; mem1_eack = 0;
        bus_cready = 0; bus_wready = 0; bus_rvalid = 0; bus_rlast = 0;
        bus_rdata = '0; bus_error = 0;
    endtask

    // Leaves the caller at the negedge of the first CMD cycle (ok=1).
    task automatic wait_cvalid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_core);
            if (bus_cvalid === 1'b1) begin
                ok = 1;
                break;
            end
            next_cycle();
        end
    endtask

    // Single-beat read completion while in XFER; no comparisons.
    task automatic finish_read();
        bus_rvalid = 1; bus_rlast = 1; fe1_rready = 1; mem1_rready = 1;
        next_cycle();
        bus_rvalid = 0; bus_rlast = 0; fe1_rready = 0; mem1_rready = 0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [79:0] obs;
        idle_inputs();
        reset_n   = 0;
        bus_rdata = 32'hA5A5_0001;
        repeat (2) next_cycle();
        @(negedge clk_core);
        obs = {bus_cvalid, bus_cmd, bus_addr, bus_wvalid, bus_wlast, bus_wdata, bus_wmask,
               bus_rready, bus_eack, bmain_cready_fe1, bmain_cready_mem1, bmain_wready_mem1,
               bmain_rvalid_fe1, bmain_rvalid_mem1, bmain_error_fe1, bmain_error_mem1};
        n_chk++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 0", obs);
        end
        n_chk++;
        if (bmain_rdata !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL rdata_broadcast: got %h, want a5a50001", bmain_rdata);
        end
        next_cycle();
        reset_n = 1;
        bus_error = 1;
        @(negedge clk_core);
        n_chk++;
        if ({bus_eack, bmain_error_fe1, bmain_error_mem1} !== 3'b100) begin
            n_err++;
            $display("FAIL idle_error_drain: got eack/err_fe1/err_mem1=%b%b%b, want 100",
                     bus_eack, bmain_error_fe1, bmain_error_mem1);
        end
        next_cycle();
        bus_error = 0;
    endtask

    task automatic test_fe1_read();
        cmd_t exp;
        bit   ok;
        fe1_cvalid = 1; fe1_addr = 27'h0000040; bus_cready = 1;
        cmd_q.push_back('{O_FE1, 1'b1, 27'h0000040});
        @(negedge clk_core);
        n_chk++;
        if (bus_cvalid !== 1'b0) begin
            n_err++;
            $display("FAIL fe1_arb_latency: bus_cvalid got %b, want 0", bus_cvalid);
        end
        next_cycle();
        fe1_cvalid = 0; fe1_addr = 27'h7FFFFFF;   // must not disturb the captured address
        wait_cvalid(8, ok);
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL fe1_grant: timeout waiting for bus_cvalid");
        end else begin
            exp = cmd_q.pop_front();
            n_chk++;
            if ({bmain_cready_fe1, bmain_cready_mem1, bus_cmd, bus_addr} !==
                {exp.owner, ~exp.owner, exp.cmd, exp.addr}) begin
                n_err++;
                $display("FAIL fe1_grant: got cready=%b%b cmd=%b addr=%h, want %b%b %b %h",
                         bmain_cready_fe1, bmain_cready_mem1, bus_cmd, bus_addr,
                         exp.owner, ~exp.owner, exp.cmd, exp.addr);
            end
        end
        next_cycle();
        bus_cready = 0;
        for (int b = 0; b < 4; b++) begin
            bus_rvalid = 1; bus_rdata = 32'h1000_0000 + b; bus_rlast = (b == 3); fe1_rready = 1;
            @(negedge clk_core);
            n_chk++;
            if ({bmain_rvalid_fe1, bmain_rvalid_mem1, bus_rready, bmain_rdata, bmain_rlast} !==
                {1'b1, 1'b0, 1'b1, 32'h1000_0000 + b, b == 3}) begin
                n_err++;
                $display("FAIL fe1_beat%0d: got rv_fe1=%b rv_mem1=%b rready=%b data=%h last=%b",
                         b, bmain_rvalid_fe1, bmain_rvalid_mem1, bus_rready, bmain_rdata, bmain_rlast);
            end
            next_cycle();
        end
        bus_rlast = 0;
        @(negedge clk_core);
        n_chk++;
        if ({bus_cvalid, bus_rready, bmain_rvalid_fe1} !== 3'b000) begin
            n_err++;
            $display("FAIL fe1_back_to_idle: got cvalid/rready/rv_fe1=%b%b%b, want 000",
                     bus_cvalid, bus_rready, bmain_rvalid_fe1);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_arbitration();
        cmd_t exp;
        bit   ok;
        idle_inputs();
        reset_n = 0;
        next_cycle();
        reset_n = 1;
`ifdef BMAIN_ARB_RR_EN
        cmd_q.push_back('{O_MEM1, 1'b1, 27'h0000200});
        cmd_q.push_back('{O_FE1,  1'b1, 27'h0000100});
        cmd_q.push_back('{O_MEM1, 1'b1, 27'h0000200});
`else
        cmd_q.push_back('{O_MEM1, 1'b1, 27'h0000200});
        cmd_q.push_back('{O_MEM1, 1'b1, 27'h0000200});
        cmd_q.push_back('{O_FE1,  1'b1, 27'h0000100});
`endif
        fe1_cvalid = 1; fe1_addr = 27'h0000100;
        mem1_cvalid = 1; mem1_cmd = 1; mem1_addr = 27'h0000200;
        bus_cready = 1;
        for (int g = 0; g < 3; g++) begin
            wait_cvalid(8, ok);
            if (!ok) begin
                n_chk++; n_err++;
                $display("FAIL arb_grant%0d: timeout waiting for bus_cvalid", g);
            end else begin
                exp = cmd_q.pop_front();
                n_chk++;
                if ({bmain_cready_fe1, bmain_cready_mem1, bus_cmd, bus_addr} !==
                    {exp.owner, ~exp.owner, exp.cmd, exp.addr}) begin
                    n_err++;
                    $display("FAIL arb_grant%0d: got cready=%b%b addr=%h, want %b%b %h", g,
                             bmain_cready_fe1, bmain_cready_mem1, bus_addr,
                             exp.owner, ~exp.owner, exp.addr);
                end
                if (g == 1) begin
                    if (exp.owner == O_FE1) fe1_cvalid = 0;
                    else                    mem1_cvalid = 0;
                end
                if (g == 2) begin
                    fe1_cvalid = 0; mem1_cvalid = 0;
                end
            end
            next_cycle();
            finish_read();
        end
        idle_inputs();
    endtask

    task automatic test_write();
        cmd_t  exp;
        beat_t eb;
        mem1_cvalid = 1; mem1_cmd = 0; mem1_addr = 27'h0000ABC;
        mem1_wvalid = 1; mem1_wdata = 32'hCAFE_0000; mem1_wmask = 4'hF; mem1_wlast = 0;
        bus_cready = 0; bus_wready = 1;
        cmd_q.push_back('{O_MEM1, 1'b0, 27'h0000ABC});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_core);
            n_chk++;
            if ({bus_cvalid, bus_wvalid, bmain_wready_mem1} !== {c != 0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL wr_pre_xfer%0d: got cvalid/wvalid/wready=%b%b%b, want %b00",
                         c, bus_cvalid, bus_wvalid, bmain_wready_mem1, c != 0);
            end
            next_cycle();
        end
        bus_cready = 1;
        @(negedge clk_core);
        exp = cmd_q.pop_front();
        n_chk++;
        if ({bus_cvalid, bmain_cready_fe1, bmain_cready_mem1, bus_cmd, bus_addr} !==
            {1'b1, exp.owner, ~exp.owner, exp.cmd, exp.addr}) begin
            n_err++;
            $display("FAIL wr_grant: got cvalid=%b cready=%b%b cmd=%b addr=%h, want 1 %b%b %b %h",
                     bus_cvalid, bmain_cready_fe1, bmain_cready_mem1, bus_cmd, bus_addr,
                     exp.owner, ~exp.owner, exp.cmd, exp.addr);
        end
        next_cycle();
        bus_cready = 0; mem1_cvalid = 0;
        for (int b = 0; b < 4; b++) begin
            mem1_wdata = 32'hCAFE_0000 + b;
            mem1_wmask = 4'(1 << b);
            mem1_wlast = (b == 3);
            beat_q.push_back('{32'hCAFE_0000 + b, 4'(1 << b), b == 3});
            @(negedge clk_core);
            eb = beat_q.pop_front();
            n_chk++;
            if ({bus_wvalid, bmain_wready_mem1, bus_wdata, bus_wmask, bus_wlast} !==
                {1'b1, 1'b1, eb.data, eb.mask, eb.last}) begin
                n_err++;
                $display("FAIL wr_beat%0d: got wv=%b wr=%b data=%h mask=%h last=%b, want 11 %h %h %b",
                         b, bus_wvalid, bmain_wready_mem1, bus_wdata, bus_wmask, bus_wlast,
                         eb.data, eb.mask, eb.last);
            end
            next_cycle();
        end
        mem1_wlast = 0;
        @(negedge clk_core);
        n_chk++;
        if ({bus_wvalid, bus_cvalid, bmain_wready_mem1} !== 3'b000) begin
            n_err++;
            $display("FAIL wr_back_to_idle: got wvalid/cvalid/wready=%b%b%b, want 000",
                     bus_wvalid, bus_cvalid, bmain_wready_mem1);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_error();
        cmd_t exp;
        bit   ok;
        fe1_cvalid = 1; fe1_addr = 27'h0000300; bus_cready = 1;
        cmd_q.push_back('{O_FE1, 1'b1, 27'h0000300});
        wait_cvalid(8, ok);
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL err_fe1_grant: timeout waiting for bus_cvalid");
        end else begin
            exp = cmd_q.pop_front();
            n_chk++;
            if ({bmain_cready_fe1, bmain_cready_mem1, bus_addr} !== {exp.owner, ~exp.owner, exp.addr}) begin
                n_err++;
                $display("FAIL err_fe1_grant: got cready=%b%b addr=%h, want %b%b %h",
                         bmain_cready_fe1, bmain_cready_mem1, bus_addr, exp.owner, ~exp.owner, exp.addr);
            end
        end
        fe1_cvalid = 0;
        mem1_cvalid = 1; mem1_cmd = 1; mem1_addr = 27'h0000400;
        cmd_q.push_back('{O_MEM1, 1'b1, 27'h0000400});
        next_cycle();
        bus_error = 1; fe1_eack = 0; mem1_eack = 1;
        @(negedge clk_core);
        n_chk++;
        if ({bmain_error_fe1, bmain_error_mem1, bus_eack} !== 3'b100) begin
            n_err++;
            $display("FAIL err_route_noack: got err_fe1/err_mem1/eack=%b%b%b, want 100",
                     bmain_error_fe1, bmain_error_mem1, bus_eack);
        end
        next_cycle();
        fe1_eack = 1;
        @(negedge clk_core);
        n_chk++;
        if ({bmain_error_fe1, bmain_error_mem1, bus_eack} !== 3'b101) begin
            n_err++;
            $display("FAIL err_route_ack: got err_fe1/err_mem1/eack=%b%b%b, want 101",
                     bmain_error_fe1, bmain_error_mem1, bus_eack);
        end
        next_cycle();
        bus_error = 0; fe1_eack = 0; mem1_eack = 0;
        @(negedge clk_core);
        n_chk++;
        if ({bus_cvalid, bmain_error_fe1, bmain_cready_mem1} !== 3'b000) begin
            n_err++;
            $display("FAIL err_to_idle: got cvalid/err_fe1/cready_mem1=%b%b%b, want 000",
                     bus_cvalid, bmain_error_fe1, bmain_cready_mem1);
        end
        next_cycle();
        wait_cvalid(8, ok);
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL err_mem1_after: timeout waiting for bus_cvalid");
        end else begin
            exp = cmd_q.pop_front();
            n_chk++;
            if ({bmain_cready_fe1, bmain_cready_mem1, bus_addr} !== {exp.owner, ~exp.owner, exp.addr}) begin
                n_err++;
                $display("FAIL err_mem1_after: got cready=%b%b addr=%h, want %b%b %h",
                         bmain_cready_fe1, bmain_cready_mem1, bus_addr, exp.owner, ~exp.owner, exp.addr);
            end
        end
        mem1_cvalid = 0;
        next_cycle();
        finish_read();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        cmd_t        exp;
        bit          ok;
        logic [10:0] obs;
        mem1_cvalid = 1; mem1_cmd = 1; mem1_addr = 27'h0000500; bus_cready = 1;
        cmd_q.push_back('{O_MEM1, 1'b1, 27'h0000500});
        wait_cvalid(8, ok);
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL rst_mid_grant: timeout waiting for bus_cvalid");
        end else begin
            exp = cmd_q.pop_front();
            n_chk++;
            if ({bmain_cready_mem1, bus_addr} !== {~exp.owner, exp.addr}) begin
                n_err++;
                $display("FAIL rst_mid_grant: got cready_mem1=%b addr=%h, want 1 %h",
                         bmain_cready_mem1, bus_addr, exp.addr);
            end
        end
        mem1_cvalid = 0;
        next_cycle();
        bus_rvalid = 1; mem1_rready = 1; bus_rlast = 0; bus_wready = 1;
        @(negedge clk_core);
        n_chk++;
        if (bmain_rvalid_mem1 !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_xfer: bmain_rvalid_mem1 got %b, want 1", bmain_rvalid_mem1);
        end
        next_cycle();
        reset_n = 0;
        next_cycle();
        reset_n = 1;
        @(negedge clk_core);
        obs = {bus_cvalid, bus_wvalid, bus_rready, bus_eack, bmain_cready_fe1, bmain_cready_mem1,
               bmain_wready_mem1, bmain_rvalid_fe1, bmain_rvalid_mem1, bmain_error_fe1, bmain_error_mem1};
        n_chk++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %b, want 0", obs);
        end
        next_cycle();
        idle_inputs();
        fe1_cvalid = 1; fe1_addr = 27'h0000600; bus_cready = 1;
        cmd_q.push_back('{O_FE1, 1'b1, 27'h0000600});
        wait_cvalid(8, ok);
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL rst_mid_fe1: timeout waiting for bus_cvalid");
        end else begin
            exp = cmd_q.pop_front();
            n_chk++;
            if ({bmain_cready_fe1, bmain_cready_mem1, bus_cmd, bus_addr} !==
                {exp.owner, ~exp.owner, exp.cmd, exp.addr}) begin
                n_err++;
                $display("FAIL rst_mid_fe1: got cready=%b%b cmd=%b addr=%h, want %b%b %b %h",
                         bmain_cready_fe1, bmain_cready_mem1, bus_cmd, bus_addr,
                         exp.owner, ~exp.owner, exp.cmd, exp.addr);
            end
        end
        fe1_cvalid = 0;
        next_cycle();
        finish_read();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        cmd_t exp;
        int   last_cmd;
        last_cmd = -1;
        cmd_q.delete();
        repeat (4) cmd_q.push_back('{O_MEM1, 1'b1, 27'h0000700});
        mem1_cvalid = 1; mem1_cmd = 1; mem1_addr = 27'h0000700;
        bus_cready = 1; bus_rvalid = 1; bus_rlast = 1; mem1_rready = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_core);
            if (bus_cvalid === 1'b1) begin
                if (last_cmd >= 0) begin
                    n_chk++;
                    if (c - last_cmd !== 3) begin
                        n_err++;
                        $display("FAIL b2b_spacing: got %0d cycles CMD-to-CMD, want 3", c - last_cmd);
                    end
                end
                last_cmd = c;
                exp = cmd_q.pop_front();
                n_chk++;
                if ({bmain_cready_mem1, bus_addr} !== {~exp.owner, exp.addr}) begin
                    n_err++;
                    $display("FAIL b2b_grant: got cready_mem1=%b addr=%h, want 1 %h",
                             bmain_cready_mem1, bus_addr, exp.addr);
                end
            end
            next_cycle();
        end
        mem1_cvalid = 0;
        n_chk++;
        if (cmd_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d grants, want 4", 4 - cmd_q.size());
        end
        next_cycle();
        idle_inputs();
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        test_reset();
        test_fe1_read();
        test_arbitration();
        test_write();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
